// File: rtl/vx_axi_write_burst_sched_pkg.sv
// vx_axi_write_burst_sched_pkg: shared types and constants for the burst-aware AXI write scheduler
package vx_axi_write_burst_sched_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/vx_axi_write_burst_sched_pending_ctr.sv
// vx_axi_write_burst_sched_pending_ctr: saturating up/down count of outstanding writes for one input
module vx_axi_write_burst_sched_pending_ctr #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full
);
    assign full = count == W'(MAX);
    // simultaneous inc and dec cancel; saturate at both ends
    always_ff @(posedge clk)
        if (reset) count <= '0;
        else if (inc && !dec && !full) count <= count + W'(1);
        else if (dec && !inc && count != '0) count <= count - W'(1);
endmodule

// File: rtl/vx_axi_write_burst_sched.sv
// vx_axi_write_burst_sched: shares one AXI4 write master between several write requesters, burst at a time
module vx_axi_write_burst_sched
    import vx_axi_write_burst_sched_pkg::*;
#(
    parameter int NUM_INPUTS     = 2,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_TID_WIDTH  = 4,
    parameter int MAX_PENDING    = 8,
    parameter int SEL_BITS       = sel_bits(NUM_INPUTS)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_INPUTS-1:0]                      s_awvalid,
    output logic [NUM_INPUTS-1:0]                      s_awready,
    input  logic [NUM_INPUTS*AXI_ADDR_WIDTH-1:0]       s_awaddr,
    input  logic [NUM_INPUTS*AXI_TID_WIDTH-1:0]        s_awid,
    input  logic [NUM_INPUTS*8-1:0]                    s_awlen,
    input  logic [NUM_INPUTS-1:0]                      s_wvalid,
    output logic [NUM_INPUTS-1:0]                      s_wready,
    input  logic [NUM_INPUTS*AXI_DATA_WIDTH-1:0]       s_wdata,
    input  logic [NUM_INPUTS*AXI_DATA_WIDTH/8-1:0]     s_wstrb,
    input  logic [NUM_INPUTS-1:0]                      s_wlast,
    output logic [NUM_INPUTS-1:0]                      s_bvalid,
    input  logic [NUM_INPUTS-1:0]                      s_bready,
    output logic [NUM_INPUTS*AXI_TID_WIDTH-1:0]        s_bid,
    output logic [NUM_INPUTS*2-1:0]                    s_bresp,
    output logic                                       m_awvalid,
    input  logic                                       m_awready,
    output logic [AXI_ADDR_WIDTH-1:0]                  m_awaddr,
    output logic [7:0]                                 m_awlen,
    output logic [AXI_TID_WIDTH+SEL_BITS-1:0]          m_awid,
    output logic                                       m_wvalid,
    input  logic                                       m_wready,
    output logic [AXI_DATA_WIDTH-1:0]                  m_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]                m_wstrb,
    output logic                                       m_wlast,
    input  logic                                       m_bvalid,
    output logic                                       m_bready,
    input  logic [AXI_TID_WIDTH+SEL_BITS-1:0]          m_bid,
    input  logic [1:0]                                 m_bresp,
    output logic                                       burst_err
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int SW = AXI_DATA_WIDTH / 8;
    localparam int TW = AXI_TID_WIDTH;
    localparam int PW = $clog2(MAX_PENDING + 1);

    state_t state, state_n;
    logic [SEL_BITS-1:0] grant, rr_ptr, pick, bsel;
    logic found, act, rst_q, aw_hs, w_hs, b_ok, b_hs;
    logic [7:0] beats;
    logic [NUM_INPUTS-1:0] elig, inc, dec, full, empty;
    logic [PW-1:0] pending [NUM_INPUTS];

    assign act   = !reset && !rst_q;
    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign bsel  = m_bid[TW +: SEL_BITS];
    assign b_hs  = m_bvalid && m_bready && b_ok;

    if ((1 << SEL_BITS) == NUM_INPUTS) begin : g_full_sel
        assign b_ok = 1'b1;
    end else begin : g_part_sel
        assign b_ok = int'(bsel) < NUM_INPUTS;
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        assign elig[i]  = s_awvalid[i] && !full[i];
        assign inc[i]   = aw_hs && grant == SEL_BITS'(i);
        assign dec[i]   = b_hs && bsel == SEL_BITS'(i);
        assign empty[i] = pending[i] == '0;
        assign s_bid[i*TW +: TW]  = m_bid[TW-1:0];
        assign s_bresp[i*2 +: 2]  = (bsel == SEL_BITS'(i)) ? m_bresp : BRESP_OKAY;
        vx_axi_write_burst_sched_pending_ctr #(.MAX(MAX_PENDING), .W(PW)) u_ctr (
            .clk(clk), .reset(reset), .inc(inc[i]), .dec(dec[i]), .count(pending[i]), .full(full[i])
        );
    end

    // round-robin pick: first eligible input at or after rr_ptr
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--)
            if (elig[(int'(rr_ptr) + k) % NUM_INPUTS]) begin
                pick  = SEL_BITS'((int'(rr_ptr) + k) % NUM_INPUTS);
                found = 1'b1;
            end
    end

    // state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    // next state: a grant is held from AW handshake through the wlast beat
    always_comb
        state_n = (state == IDLE && found) ? ADDR :
                  (state == ADDR && aw_hs) ? DATA :
                  (state == DATA && w_hs && m_wlast) ? IDLE : state;

    // grant, round-robin pointer, beat counter and sticky length-error flag
    always_ff @(posedge clk) begin
        rst_q <= reset;
        if (reset) begin
            grant     <= '0;
            rr_ptr    <= '0;
            beats     <= '0;
            burst_err <= 1'b0;
        end else begin
            if (state == IDLE && found) grant <= pick;
            if (aw_hs) beats <= m_awlen;
            if (w_hs) begin
                if (m_wlast ? beats != '0 : beats == '0) burst_err <= 1'b1;
                if (beats != '0) beats <= beats - 8'd1;
                if (m_wlast) rr_ptr <= (grant == SEL_BITS'(NUM_INPUTS - 1)) ? '0 : grant + SEL_BITS'(1);
            end
        end
    end

    // channel muxing: AW/W from the granted input, B routed by the ID select bits
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        m_awvalid = act && state == ADDR && s_awvalid[grant];
        m_awaddr  = s_awaddr[int'(grant)*AW +: AW];
        m_awlen   = s_awlen[int'(grant)*8 +: 8];
        m_awid    = {grant, s_awid[int'(grant)*TW +: TW]};
        m_wvalid  = act && state == DATA && s_wvalid[grant];
        m_wdata   = s_wdata[int'(grant)*DW +: DW];
        m_wstrb   = s_wstrb[int'(grant)*SW +: SW];
        m_wlast   = s_wlast[grant];
        s_awready[grant] = act && state == ADDR && m_awready;
        s_wready[grant]  = act && state == DATA && m_wready;
        if (b_ok) s_bvalid[bsel] = act && m_bvalid;
        m_bready  = act && (b_ok ? s_bready[bsel] : 1'b1);
    end

    a_b_underflow: assert property (@(posedge clk) disable iff (reset) b_hs |-> !empty[bsel]);
    a_b_sel_range: assert property (@(posedge clk) disable iff (reset) m_bvalid |-> b_ok);
endmodule
